// File: rtl/piso_pkg.sv
// Shared types and the one-bit shift step used by the PISO serializer.
// The step operates on a 64-bit container so a single function serves every WIDTH.
package piso_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    typedef struct packed {
        logic             nxt_bit;
        logic [MAX_W-1:0] sreg;
    } piso_shift_t;

    // Takes the bit at the output end and shifts the word one place toward it.
    // MSB-first leaves junk above bit w-1; callers keep only the low w bits.
    function automatic piso_shift_t piso_shift(input logic [MAX_W-1:0] s,
                                               input logic             dir,
                                               input int unsigned      w);
        piso_shift_t r;
        logic [5:0]  top_idx;
        top_idx = 6'(w - 1);
        if (dir) begin
            r.nxt_bit = s[top_idx];
            r.sreg    = s << 1;
        end else begin
            r.nxt_bit = s[0];
            r.sreg    = s >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter with clear, enable and a terminal flag at WIDTH-1.
// Shared between the serializer and a future deserializer.
module piso_bit_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_en,
    output logic [$clog2(WIDTH)-1:0] o_cnt,
    output logic                     o_last
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready input, per-word bit order,
// frame markers and gapless back-to-back streaming.
//
//   state | meaning
//   IDLE  | no frame; in_ready high, all serial outputs low
//   SHIFT | frame in progress; serial_out holds the current bit until shift_en
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_msb_first,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);
    localparam int unsigned CW = $clog2(WIDTH);

    piso_state_t      r_state;
    logic [WIDTH-1:0] r_sreg;
    logic             r_dir;
    logic             r_serial_out;
    logic             r_serial_valid;
    logic             r_frame_start;
    logic             r_frame_end;

    logic [CW-1:0]    w_cnt;
    logic             w_last;
    logic             w_accept;
    logic             w_cnt_en;
    logic             w_end_next;
    piso_shift_t      w_acc;
    piso_shift_t      w_sh;
    logic             w_unused_hi;

    // Ready on the last bit's strobe lets the next word follow without a gap.
    assign in_ready   = (r_state == IDLE) || ((r_state == SHIFT) && shift_en && w_last);
    assign w_accept   = in_valid && in_ready;
    assign w_cnt_en   = (r_state == SHIFT) && shift_en && !w_last;
    assign w_end_next = (w_cnt == CW'(WIDTH - 2));

    assign w_acc = piso_shift(MAX_W'(in_data), in_msb_first, WIDTH);
    assign w_sh  = piso_shift(MAX_W'(r_sreg), r_dir, WIDTH);
    assign w_unused_hi = ^{w_acc.sreg, w_sh.sreg};

    piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_accept),
        .i_en   (w_cnt_en),
        .o_cnt  (w_cnt),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_sreg         <= '0;
            r_dir          <= 1'b0;
            r_serial_out   <= 1'b0;
            r_serial_valid <= 1'b0;
            r_frame_start  <= 1'b0;
            r_frame_end    <= 1'b0;
        end else if (w_accept) begin
            r_state        <= SHIFT;
            r_sreg         <= w_acc.sreg[WIDTH-1:0];
            r_dir          <= in_msb_first;
            r_serial_out   <= w_acc.nxt_bit;
            r_serial_valid <= 1'b1;
            r_frame_start  <= 1'b1;
            r_frame_end    <= 1'b0;
        end else if ((r_state == SHIFT) && shift_en) begin
            if (!w_last) begin
                r_sreg        <= w_sh.sreg[WIDTH-1:0];
                r_serial_out  <= w_sh.nxt_bit;
                r_frame_start <= 1'b0;
                r_frame_end   <= w_end_next;
            end else begin
                r_state        <= IDLE;
                r_serial_out   <= 1'b0;
                r_serial_valid <= 1'b0;
                r_frame_start  <= 1'b0;
                r_frame_end    <= 1'b0;
            end
        end
    end

    assign serial_out   = r_serial_out;
    assign serial_valid = r_serial_valid;
    assign frame_start  = r_frame_start;
    assign frame_end    = r_frame_end;
    assign busy         = r_serial_valid;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: fixed vector table, directed corner sequences and
// random traffic, all checked against a frame-position model.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_msb_first;
    logic         shift_en;
    logic         serial_out;
    logic         serial_valid;
    logic         frame_start;
    logic         frame_end;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    // frame-level model: which word, which order, which bit is on the wire
    logic         m_active;
    int           m_pos;
    logic [W-1:0] m_word;
    logic         m_msb;
    logic         ready_pre;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_msb_first (in_msb_first),
        .shift_en     (shift_en),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_bit(input logic [W-1:0] w, input logic msb, input int p);
        return msb ? w[W-1-p] : w[p];
    endfunction

    // One clock: drive inputs, check ready before the edge, step the model, check outputs after.
    task automatic cycle(input logic r, input logic v, input logic [W-1:0] d,
                         input logic msb, input logic en);
        logic exp_ready;
        rst = r; in_valid = v; in_data = d; in_msb_first = msb; shift_en = en;
        #1;
        exp_ready = !m_active || (en && m_pos == W - 1);
        ready_pre = in_ready;
        chk("in_ready", in_ready, exp_ready);
        @(posedge clk);
        if (r) begin
            m_active = 1'b0;
        end else if (v && exp_ready) begin
            m_active = 1'b1; m_pos = 0; m_word = d; m_msb = msb;
        end else if (m_active && en) begin
            if (m_pos < W - 1) m_pos++;
            else m_active = 1'b0;
        end
        #1;
        chk("serial_valid", serial_valid, m_active);
        chk("busy", busy, m_active);
        chk("serial_out", serial_out, m_active ? model_bit(m_word, m_msb, m_pos) : 1'b0);
        chk("frame_start", frame_start, m_active && m_pos == 0);
        chk("frame_end", frame_end, m_active && m_pos == W - 1);
    endtask

    typedef struct {
        logic         valid;
        logic [W-1:0] data;
        logic         msb;
        logic         en;
        logic         e_ready;
        logic         e_out;
        logic         e_valid;
        logic         e_start;
        logic         e_end;
    } vec_t;

    function automatic vec_t mkv(input logic v, input logic [W-1:0] d, input logic msb,
                                 input logic en, input logic rdy, input logic o,
                                 input logic sv, input logic st, input logic fe);
        vec_t x;
        x.valid = v; x.data = d; x.msb = msb; x.en = en;
        x.e_ready = rdy; x.e_out = o; x.e_valid = sv; x.e_start = st; x.e_end = fe;
        return x;
    endfunction

    vec_t vecs[10];

    initial begin
        int cnt_valid;
        int cnt_start;
        int cnt_ready;
        logic [W-1:0] got;

        // A5 MSB-first with shift_en every cycle: 1,0,1,0,0,1,0,1
        vecs[0] = mkv(1, 8'hA5, 1, 1, 1, 1, 1, 1, 0);
        vecs[1] = mkv(0, 8'h00, 0, 1, 0, 0, 1, 0, 0);
        vecs[2] = mkv(0, 8'h00, 0, 1, 0, 1, 1, 0, 0);
        vecs[3] = mkv(0, 8'h00, 0, 1, 0, 0, 1, 0, 0);
        vecs[4] = mkv(0, 8'h00, 0, 1, 0, 0, 1, 0, 0);
        vecs[5] = mkv(0, 8'h00, 0, 1, 0, 1, 1, 0, 0);
        vecs[6] = mkv(0, 8'h00, 0, 1, 0, 0, 1, 0, 0);
        vecs[7] = mkv(0, 8'h00, 0, 1, 0, 1, 1, 0, 1);
        vecs[8] = mkv(0, 8'h00, 0, 1, 1, 0, 0, 0, 0);
        vecs[9] = mkv(0, 8'h00, 0, 1, 1, 0, 0, 0, 0);

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_msb_first = 1'b0; shift_en = 1'b0;
        m_active = 1'b0; m_pos = 0; m_word = '0; m_msb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_serial_out", serial_out, 1'b0);
        chk("rst_serial_valid", serial_valid, 1'b0);
        chk("rst_frame_start", frame_start, 1'b0);
        chk("rst_frame_end", frame_end, 1'b0);
        chk("rst_busy", busy, 1'b0);

        for (int i = 0; i < 5; i++) cycle(0, 0, 8'h5A, 1, 1'(i % 2));

        for (int i = 0; i < 10; i++) begin
            cycle(0, vecs[i].valid, vecs[i].data, vecs[i].msb, vecs[i].en);
            chk("tbl_ready", ready_pre, vecs[i].e_ready);
            chk("tbl_out", serial_out, vecs[i].e_out);
            chk("tbl_valid", serial_valid, vecs[i].e_valid);
            chk("tbl_start", frame_start, vecs[i].e_start);
            chk("tbl_end", frame_end, vecs[i].e_end);
        end

        // LSB-first with a slow strobe: each bit held for three cycles
        cycle(0, 1, 8'hA5, 0, 0);
        cnt_valid = serial_valid ? 1 : 0;
        got = '0;
        for (int i = 0; i < 26; i++) begin
            if (i % 3 == 2 && serial_valid) got = {serial_out, got[W-1:1]};
            cycle(0, 0, 8'h00, 0, 1'(i % 3 == 2));
            if (serial_valid) cnt_valid++;
        end
        chk("slow_valid_cycles", cnt_valid, 24);
        chk("slow_word_lsb", got, 8'hA5);

        // back-to-back FF then 00 with in_valid held
        cnt_valid = 0; cnt_start = 0; cnt_ready = 0;
        cycle(0, 1, 8'hFF, 1, 1);
        if (serial_valid) cnt_valid++;
        if (frame_start) cnt_start++;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 8'h00, 1, 1);
            if (ready_pre) cnt_ready++;
            if (serial_valid) cnt_valid++;
            if (frame_start) cnt_start++;
        end
        for (int i = 0; i < 9; i++) begin
            cycle(0, 0, 8'h00, 1, 1);
            if (serial_valid) cnt_valid++;
            if (frame_start) cnt_start++;
        end
        chk("b2b_valid_cycles", cnt_valid, 16);
        chk("b2b_frame_starts", cnt_start, 2);
        chk("b2b_ready_pulses", cnt_ready, 1);

        // reset mid-frame, then a clean 81
        cycle(0, 1, 8'hC3, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 1, 1);
        cycle(1, 0, 8'h00, 1, 1);
        chk("midrst_valid", serial_valid, 1'b0);
        chk("midrst_out", serial_out, 1'b0);
        cycle(0, 1, 8'h81, 1, 1);
        got = '0;
        for (int i = 0; i < 8; i++) begin
            got = {got[W-2:0], serial_out};
            cycle(0, 0, 8'h00, 1, 1);
        end
        chk("after_rst_word", got, 8'h81);
        chk("after_rst_idle", serial_valid, 1'b0);

        // reset wins over a simultaneous accept
        cycle(1, 1, 8'hFF, 1, 1);
        chk("rst_vs_accept", serial_valid, 1'b0);
        cycle(0, 0, 8'h00, 1, 1);
        chk("rst_vs_accept_next", serial_valid, 1'b0);

        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 2) != 0),
                  W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
